// File: rtl/mem_tg_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_tg_cfg_seq
// Brief    : Programs a memory traffic generator over its CSR window, starts
//            it, polls TEST_COMPLETE and collects pass/fail/fail-count.
// Revision : 1.0
// ============================================================================
module mem_tg_cfg_seq #(
    parameter int TG_ADDR_W      = 12,
    parameter int POLL_INTERVAL  = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          loop_count,
    input  logic [31:0]          write_count,
    input  logic [31:0]          read_count,
    input  logic [31:0]          burst_length,
    input  logic [63:0]          seq_start_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [31:0]          fail_count,
    output logic [TG_ADDR_W-1:0] tg_address,
    output logic                 tg_write,
    output logic                 tg_read,
    output logic [31:0]          tg_writedata,
    input  logic [31:0]          tg_readdata,
    input  logic                 tg_readdatavalid,
    input  logic                 tg_waitrequest
);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_CFG   = 4'd1;
    localparam logic [3:0] c_GO    = 4'd2;
    localparam logic [3:0] c_PWAIT = 4'd3;
    localparam logic [3:0] c_PRD   = 4'd4;
    localparam logic [3:0] c_PRSP  = 4'd5;
    localparam logic [3:0] c_RPASS = 4'd6;
    localparam logic [3:0] c_RFAIL = 4'd7;
    localparam logic [3:0] c_RFCNT = 4'd8;
    localparam logic [3:0] c_DONE  = 4'd9;

    localparam logic [31:0] c_TMO_LIM   = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] c_POLL_LAST = 32'(POLL_INTERVAL - 1);

    logic [3:0]           r_state;
    logic [2:0]           r_idx;
    logic [31:0]          r_loop_count;
    logic [31:0]          r_write_count;
    logic [31:0]          r_read_count;
    logic [31:0]          r_burst_length;
    logic [63:0]          r_seq_addr;
    logic [31:0]          r_poll_cnt;
    logic [31:0]          r_tmo_cnt;
    logic                 r_tmo_run;
    logic                 r_rd_wait;
    logic                 r_pass;
    logic                 r_fail;
    logic                 r_timeout;
    logic [31:0]          r_fail_count;
    logic                 r_tg_write;
    logic                 r_tg_read;
    logic [TG_ADDR_W-1:0] r_tg_address;
    logic [31:0]          r_tg_writedata;

    logic [11:0]          w_cfg_addr;
    logic [31:0]          w_cfg_data;
    logic [11:0]          w_res_addr;
    logic                 w_tmo_hit;

    always_comb begin
        w_cfg_addr = 12'h008;
        w_cfg_data = r_loop_count;
        case (r_idx)
            3'd0: begin w_cfg_addr = 12'h008; w_cfg_data = r_loop_count;       end
            3'd1: begin w_cfg_addr = 12'h00C; w_cfg_data = r_write_count;      end
            3'd2: begin w_cfg_addr = 12'h010; w_cfg_data = r_read_count;       end
            3'd3: begin w_cfg_addr = 12'h01C; w_cfg_data = r_burst_length;     end
            3'd4: begin w_cfg_addr = 12'h040; w_cfg_data = r_seq_addr[31:0];   end
            3'd5: begin w_cfg_addr = 12'h044; w_cfg_data = r_seq_addr[63:32];  end
            3'd6: begin w_cfg_addr = 12'h078; w_cfg_data = r_seq_addr[31:0];   end
            3'd7: begin w_cfg_addr = 12'h07C; w_cfg_data = r_seq_addr[63:32];  end
        endcase
    end

    always_comb begin
        w_res_addr = 12'h088;
        if (r_state == c_RFAIL) w_res_addr = 12'h08C;
        if (r_state == c_RFCNT) w_res_addr = 12'h090;
    end

    // The counter saturates, so once the limit is reached this stays true.
    assign w_tmo_hit = r_tmo_run && (r_tmo_cnt >= c_TMO_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= c_IDLE;
            r_idx          <= '0;
            r_loop_count   <= '0;
            r_write_count  <= '0;
            r_read_count   <= '0;
            r_burst_length <= '0;
            r_seq_addr     <= '0;
            r_poll_cnt     <= '0;
            r_tmo_cnt      <= '0;
            r_tmo_run      <= 1'b0;
            r_rd_wait      <= 1'b0;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_timeout      <= 1'b0;
            r_fail_count   <= '0;
            r_tg_write     <= 1'b0;
            r_tg_read      <= 1'b0;
            r_tg_address   <= '0;
            r_tg_writedata <= '0;
        end else begin
            if (r_tmo_run && (r_tmo_cnt != 32'hFFFF_FFFF)) r_tmo_cnt <= r_tmo_cnt + 32'd1;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_loop_count   <= loop_count;
                        r_write_count  <= write_count;
                        r_read_count   <= read_count;
                        r_burst_length <= burst_length;
                        r_seq_addr     <= seq_start_addr;
                        r_pass         <= 1'b0;
                        r_fail         <= 1'b0;
                        r_timeout      <= 1'b0;
                        r_fail_count   <= '0;
                        r_idx          <= '0;
                        r_state        <= c_CFG;
                    end
                end
                c_CFG: begin
                    if (!r_tg_write) begin
                        r_tg_write     <= 1'b1;
                        r_tg_address   <= TG_ADDR_W'(w_cfg_addr);
                        r_tg_writedata <= w_cfg_data;
                    end else if (!tg_waitrequest) begin
                        r_tg_write <= 1'b0;
                        r_idx      <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= c_GO;
                    end
                end
                c_GO: begin
                    if (!r_tg_write) begin
                        r_tg_write     <= 1'b1;
                        r_tg_address   <= TG_ADDR_W'(12'h004);
                        r_tg_writedata <= 32'd1;
                    end else if (!tg_waitrequest) begin
                        r_tg_write <= 1'b0;
                        r_tmo_cnt  <= '0;
                        r_tmo_run  <= 1'b1;
                        r_poll_cnt <= '0;
                        r_state    <= c_PWAIT;
                    end
                end
                c_PWAIT: begin
                    if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_tmo_run <= 1'b0;
                        r_state   <= c_DONE;
                    end else if (r_poll_cnt == c_POLL_LAST) begin
                        r_poll_cnt <= '0;
                        r_state    <= c_PRD;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 32'd1;
                    end
                end
                c_PRD: begin
                    if (!r_tg_read) begin
                        if (w_tmo_hit) begin
                            r_timeout <= 1'b1;
                            r_tmo_run <= 1'b0;
                            r_state   <= c_DONE;
                        end else begin
                            r_tg_read    <= 1'b1;
                            r_tg_address <= TG_ADDR_W'(12'h0A8);
                        end
                    end else if (!tg_waitrequest) begin
                        r_tg_read <= 1'b0;
                        r_state   <= c_PRSP;
                    end
                end
                c_PRSP: begin
                    // A poll in flight at the limit is drained; its completion bit is ignored.
                    if (tg_readdatavalid) begin
                        if (w_tmo_hit) begin
                            r_timeout <= 1'b1;
                            r_tmo_run <= 1'b0;
                            r_state   <= c_DONE;
                        end else if (tg_readdata[0]) begin
                            r_tmo_run <= 1'b0;
                            r_state   <= c_RPASS;
                        end else begin
                            r_state <= c_PWAIT;
                        end
                    end
                end
                c_RPASS, c_RFAIL, c_RFCNT: begin
                    if (!r_rd_wait) begin
                        if (!r_tg_read) begin
                            r_tg_read    <= 1'b1;
                            r_tg_address <= TG_ADDR_W'(w_res_addr);
                        end else if (!tg_waitrequest) begin
                            r_tg_read <= 1'b0;
                            r_rd_wait <= 1'b1;
                        end
                    end else if (tg_readdatavalid) begin
                        r_rd_wait <= 1'b0;
                        if (r_state == c_RPASS) begin
                            r_pass  <= tg_readdata[0];
                            r_state <= c_RFAIL;
                        end else if (r_state == c_RFAIL) begin
                            r_fail  <= tg_readdata[0];
                            r_state <= c_RFCNT;
                        end else begin
                            r_fail_count <= tg_readdata;
                            r_state      <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state != c_IDLE) && (r_state != c_DONE);
    assign done         = (r_state == c_DONE);
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign timeout      = r_timeout;
    assign fail_count   = r_fail_count;
    assign tg_address   = r_tg_address;
    assign tg_write     = r_tg_write;
    assign tg_read      = r_tg_read;
    assign tg_writedata = r_tg_writedata;

endmodule
`default_nettype wire

// File: tb/tb_mem_tg_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_tg_cfg_seq
// Brief    : Scoreboard bench for mem_tg_cfg_seq with an Avalon CSR slave model.
// Revision : 1.0
// ============================================================================
module tb_mem_tg_cfg_seq;

    localparam int c_TMO = 500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] loop_count, write_count, read_count, burst_length;
    logic [63:0] seq_start_addr;
    logic        busy, done, pass, fail, timeout;
    logic [31:0] fail_count;
    logic [11:0] tg_address;
    logic        tg_write, tg_read;
    logic [31:0] tg_writedata;
    logic [31:0] tg_readdata;
    logic        tg_readdatavalid;
    logic        tg_waitrequest;

    mem_tg_cfg_seq #(
        .TG_ADDR_W      (12),
        .POLL_INTERVAL  (64),
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .loop_count       (loop_count),
        .write_count      (write_count),
        .read_count       (read_count),
        .burst_length     (burst_length),
        .seq_start_addr   (seq_start_addr),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail             (fail),
        .timeout          (timeout),
        .fail_count       (fail_count),
        .tg_address       (tg_address),
        .tg_write         (tg_write),
        .tg_read          (tg_read),
        .tg_writedata     (tg_writedata),
        .tg_readdata      (tg_readdata),
        .tg_readdatavalid (tg_readdatavalid),
        .tg_waitrequest   (tg_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic p; logic f; logic [31:0] fc; logic t; } res_t;

    wr_t  exp_wr[$];
    res_t exp_res[$];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    // Slave model knobs and observations
    int          stall_max = 0;
    int          complete_after = 0;
    bit          tmo_mode = 0;
    bit          force_wait = 0;
    logic        pass_val = 1'b0, fail_val = 1'b0;
    logic [31:0] fcnt_val = '0;
    int          polls = 0, res_reads = 0, cyc = 0, go_cyc = 0, last_poll_cyc = 0;
    bit          go_seen = 0, held_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    // Avalon CSR slave: decides waitrequest/readdatavalid on the falling edge
    // and scores each command accepted at the preceding rising edge.
    initial begin : g_slave
        logic        prev_wr, prev_rd, prev_wait, rsp_pending, held_rsp;
        logic [11:0] prev_addr;
        logic [31:0] prev_data, rsp_data;
        int          stall_left, rsp_cnt;
        wr_t         e;
        prev_wr = 0; prev_rd = 0; prev_wait = 0; rsp_pending = 0; held_rsp = 0;
        prev_addr = '0; prev_data = '0; rsp_data = '0; stall_left = 0; rsp_cnt = 0;
        tg_waitrequest = 1'b0; tg_readdatavalid = 1'b0; tg_readdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (go_seen) go_cyc++;
            if (!rst_n) begin
                prev_wr = 0; prev_rd = 0; prev_wait = 0; rsp_pending = 0;
                tg_waitrequest = 1'b0; tg_readdatavalid = 1'b0;
                continue;
            end
            if ((prev_wr || prev_rd) && prev_wait) begin
                check("cmd_stable", {tg_write, tg_read, tg_address, tg_writedata},
                      {prev_wr, prev_rd, prev_addr, prev_data});
            end else if (prev_wr) begin
                if (exp_wr.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", prev_addr, prev_data);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", prev_addr, e.addr);
                    check("wr_data", prev_data, e.data);
                end
                if (prev_addr == 12'h004) begin go_seen = 1; go_cyc = 0; end
            end else if (prev_rd) begin
                rsp_pending = 1; held_rsp = 0;
                rsp_cnt = $urandom_range(0, stall_max);
                case (prev_addr)
                    12'h0A8: begin
                        polls++;
                        if (polls > 1) check("poll_gap_ge_65", (cyc - last_poll_cyc) >= 65, 1);
                        last_poll_cyc = cyc;
                        rsp_data = {31'h0000_1234, (!tmo_mode && polls > complete_after)};
                        if (tmo_mode && go_cyc >= 430 && go_cyc < 500) begin
                            rsp_cnt  = 520 - go_cyc;
                            held_rsp = 1;
                        end
                    end
                    12'h088: begin res_reads++; rsp_data = {31'h2AB0_0000, pass_val}; end
                    12'h08C: begin res_reads++; rsp_data = {31'h1550_0000, fail_val}; end
                    12'h090: begin res_reads++; rsp_data = fcnt_val; end
                    default: begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_read: got addr 0x%0h, expected a known CSR", prev_addr);
                        rsp_data = '0;
                    end
                endcase
            end
            tg_readdatavalid = 1'b0;
            if (rsp_pending) begin
                if (rsp_cnt == 0) begin
                    tg_readdatavalid = 1'b1;
                    tg_readdata      = rsp_data;
                    rsp_pending      = 0;
                    if (held_rsp) held_done = 1;
                end else begin
                    rsp_cnt--;
                end
            end
            if ((tg_write || tg_read) && !((prev_wr || prev_rd) && prev_wait))
                stall_left = $urandom_range(0, stall_max);
            prev_wait = force_wait || ((tg_write || tg_read) && stall_left > 0);
            if (!force_wait && (tg_write || tg_read) && stall_left > 0) stall_left--;
            tg_waitrequest = prev_wait;
            prev_wr = tg_write; prev_rd = tg_read; prev_addr = tg_address; prev_data = tg_writedata;
        end
    end

    // Result monitor: scores every done pulse against the expected result.
    initial begin : g_done_mon
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                done_cnt++;
                if (exp_res.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no pulse");
                end else begin
                    r = exp_res.pop_front();
                    check("res_pass", pass, r.p);
                    check("res_fail", fail, r.f);
                    check("res_fail_count", fail_count, r.fc);
                    check("res_timeout", timeout, r.t);
                    check("busy_at_done", busy, 0);
                end
            end
        end
    end

    task automatic run_start(input logic [31:0] lc, input logic [31:0] wc, input logic [31:0] rc,
                             input logic [31:0] bl, input logic [63:0] ad, input logic ep,
                             input logic ef, input logic [31:0] efc, input logic et);
        res_t r;
        push_wr(12'h008, lc);         push_wr(12'h00C, wc);
        push_wr(12'h010, rc);         push_wr(12'h01C, bl);
        push_wr(12'h040, ad[31:0]);   push_wr(12'h044, ad[63:32]);
        push_wr(12'h078, ad[31:0]);   push_wr(12'h07C, ad[63:32]);
        push_wr(12'h004, 32'd1);
        r.p = ep; r.f = ef; r.fc = efc; r.t = et;
        exp_res.push_back(r);
        polls = 0; res_reads = 0; held_done = 0; go_seen = 0;
        loop_count = lc; write_count = wc; read_count = rc; burst_length = bl; seq_start_addr = ad;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("flags_clear_on_start", {pass, fail, timeout}, 0);
        check("fail_count_clear_on_start", fail_count, 0);
        check("no_write_before_cfg", tg_write, 0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < budget) begin
            tick();
            k++;
        end
        if (done_cnt == n0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_no_done: got no done in %0d cycles, expected one pulse", name, budget);
        end
        tick(3);
        check({name, "_done_once"}, done_cnt - n0, 1);
        check({name, "_idle"}, busy, 0);
        check({name, "_writes_left"}, exp_wr.size(), 0);
    endtask

    initial begin : g_main
        int k;
        rst_n = 1'b0; start = 1'b0;
        loop_count = '0; write_count = '0; read_count = '0; burst_length = '0; seq_start_addr = '0;
        tick(3);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_flags", {pass, fail, timeout}, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_cmd", {tg_write, tg_read, tg_address, tg_writedata}, 0);
        rst_n = 1'b1;
        tick(2);

        // Basic run: three incomplete polls, then PASS
        stall_max = 0; complete_after = 3; tmo_mode = 0;
        pass_val = 1'b1; fail_val = 1'b0; fcnt_val = 32'h0;
        run_start(32'd1, 32'd4, 32'd4, 32'd2, 64'h1_0000_0040, 1'b1, 1'b0, 32'h0, 1'b0);
        wait_done("basic", 2000);
        check("basic_polls", polls, 4);
        check("basic_result_reads", res_reads, 3);

        // Stalled slave, FAIL with a failure count
        stall_max = 5; complete_after = 1;
        pass_val = 1'b0; fail_val = 1'b1; fcnt_val = 32'h2A;
        run_start(32'hDEAD_0001, 32'h100, 32'h80, 32'h10, 64'hCAFE_F00D_1234_5678,
                  1'b0, 1'b1, 32'h2A, 1'b0);
        wait_done("stall_fail", 4000);
        check("stall_fail_polls", polls, 2);

        // Completion never reported; a poll response is held across the limit
        stall_max = 0; tmo_mode = 1;
        run_start(32'd2, 32'd3, 32'd5, 32'd7, 64'h8_0000_0000, 1'b0, 1'b0, 32'h0, 1'b1);
        wait_done("timeout", 3000);
        check("timeout_result_reads", res_reads, 0);
        check("timeout_held_rsp_consumed", held_done, 1);

        // Second start while in CFG must be ignored
        tmo_mode = 0; stall_max = 2; complete_after = 0;
        pass_val = 1'b1; fail_val = 1'b0; fcnt_val = 32'h0;
        run_start(32'd9, 32'd8, 32'd7, 32'd6, 64'h1_0000_1000, 1'b1, 1'b0, 32'h0, 1'b0);
        tick(4);
        check("cfg_busy_before_restart", busy, 1);
        loop_count = 32'hBAD0_0BAD; seq_start_addr = 64'hFFFF_0000_FFFF_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("start_in_cfg", 3000);

        // Reset while a write is stalled
        stall_max = 0;
        run_start(32'd1, 32'd1, 32'd1, 32'd1, 64'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        force_wait = 1;
        tick(2);
        k = 0;
        while (!tg_write && k < 20) begin
            tick();
            k++;
        end
        check("write_stalled_before_reset", {tg_write, tg_waitrequest}, 2'b11);
        rst_n = 1'b0;
        tick();
        check("mid_rst_write", tg_write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flags", {pass, fail, timeout, done}, 0);
        check("mid_rst_fail_count", fail_count, 0);
        rst_n = 1'b1;
        force_wait = 0;
        exp_wr.delete();
        exp_res.delete();
        tick(2);

        // Clean run after the reset
        complete_after = 0; pass_val = 1'b1; fail_val = 1'b0; fcnt_val = 32'h0;
        run_start(32'd3, 32'd2, 32'd1, 32'd4, 64'hFFFF_FFFF_0000_0080, 1'b1, 1'b0, 32'h0, 1'b0);
        wait_done("after_reset", 2000);
        check("after_reset_polls", polls, 1);
        check("after_reset_result_reads", res_reads, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
